pe_host_drv: RTL and testbench
==============================

// Module: pe_host_drv
// PURPOSE
//  Host-side driver for the 2x2 PE array's push/pop interface: accepts 2x2 operand jobs (A,B + tag)
//  over valid/ready and pushes them into the array (ain/bin/psh). It also pops 2x2 results
//  (cout/cout_val/pop) and returns them in order with their tag over valid/ready.
//  The PE input side has no back-pressure, so this block owns flow control via an outstanding-job credit counter.
// PARAMETERS
//  WIDTH    4     operand element width; result element width is 2*WIDTH+1
//  TAG_W    4     request/response tag width
//  MAX_OUT  2     max jobs in flight (pushed, result not yet popped); 1..3, sized to PE input FIFO depth
//  TIMEOUT  64    cycles without a pop while jobs are in flight before err_timeout
// PORTS
//  clk          in   1                clock
//  rst          in   1                synchronous reset, active-high
//  req_val      in   1                job request valid
//  req_rdy      out  1                job request ready
//  req_a        in   [3:0][WIDTH-1:0] operand A elements
//  req_b        in   [3:0][WIDTH-1:0] operand B elements
//  req_tag      in   TAG_W            job tag, returned with result
//  pe_ain       out  [3:0][WIDTH-1:0] to PE array ain
//  pe_bin       out  [3:0][WIDTH-1:0] to PE array bin
//  pe_psh       out  1                to PE array psh, 1-cycle pulse per job
//  pe_cout      in   [3:0][2*WIDTH:0] from PE array result
//  pe_cout_val  in   1                from PE array result valid
//  pe_pop       out  1                to PE array result pop
//  rsp_val      out  1                result valid
//  rsp_rdy      in   1                result ready
//  rsp_c        out  [3:0][2*WIDTH:0] result elements, copied verbatim from pe_cout
//  rsp_tag      out  TAG_W            tag of the job this result belongs to
//  flush        in   1                1-cycle pulse: stop accepting, drain all in-flight jobs
//  busy         out  1                credits!=0 | rsp_val | state!=RUN
//  err_timeout  out  1                sticky timeout error
// BEHAVIOUR
//  Reset: state=RUN, credits=0, tag FIFO empty, timer=0.
//    All outputs 0 (pe_ain/pe_bin/rsp_c/rsp_tag = 0), except req_rdy, which is combinational.
//  States:
//    RUN   -> FLUSH on flush; -> ERR on timer==TIMEOUT.
//    FLUSH -> RUN when credits==0 & !rsp_val; -> ERR on timer==TIMEOUT.
//    ERR   -> exits only on rst.
//  req_rdy = (state==RUN) & (credits<MAX_OUT). Combinational; does not depend on req_val.
//  Accept = req_val & req_rdy. Registered issue:
//    - cycle after accept: pe_psh=1, pe_ain=req_a, pe_bin=req_b.
//    - otherwise pe_psh=0; pe_ain/pe_bin hold their last values.
//    - on accept, req_tag is written into an in-order tag FIFO of depth MAX_OUT.
//  Back-to-back accepts give back-to-back psh pulses.
//  credits: +1 on accept, -1 on pe_pop; both in the same cycle = no change. Never exceeds MAX_OUT, never underflows.
//  pe_pop = pe_cout_val & (!rsp_val | rsp_rdy) & (credits!=0). Combinational; pops at most one result per cycle.
//  Response register (1 entry), on pe_pop:
//    - rsp_c <= pe_cout, rsp_tag <= tag FIFO head (head popped), rsp_val <= 1.
//    - rsp_val clears on rsp_rdy without a same-cycle pe_pop. Pop+handshake in the same cycle reloads: 1 result/cycle throughput.
//  rsp_c/rsp_tag are held stable while rsp_val & !rsp_rdy.
//  pe_cout_val with credits==0: no pop, ignored.
//  flush while in FLUSH or ERR: ignored. flush and accept in the same cycle: the accept completes, then FLUSH.
//  Timer:
//    - counts while credits!=0 & !pe_pop; cleared on pe_pop or when credits==0; saturates at TIMEOUT.
//    - reaching TIMEOUT -> ERR, err_timeout=1 until rst.
//  ERR: req_rdy=0; pops and responses continue so late results still drain.
//  rst mid-operation: everything returns to reset values next cycle; in-flight jobs are discarded.
//    The PE array must be reset in the same cycle.
//  Latency: accept -> pe_psh is 1 cycle; pe_pop -> rsp_val is 1 cycle.
// TESTING
//  1 Single job: A={1,2,3,4}, B={5,6,7,8}, tag=3; model returns pe_cout={19,22,43,50}
//    -> pe_psh 1 cycle after accept; rsp_c={19,22,43,50}, rsp_tag=3; busy returns to 0.
//  2 Credit limit (MAX_OUT=2): 3 back-to-back requests, no results
//    -> req_rdy=0 after 2 accepts; stays 0 until first pe_pop, third accept in that cycle or after.
//  3 Back-pressure: hold rsp_rdy=0 with 2 results pending
//    -> exactly one pop; rsp_c stable; pe_pop=0 until rsp_rdy=1, then tags delivered in order 5,6.
//  4 Flush: accept tags 1,2, pulse flush, keep req_val=1
//    -> no new accepts; RUN re-entered after both responses drained; next request accepted.
//  5 Timeout (TIMEOUT=8): 1 job, model never asserts cout_val
//    -> err_timeout=1 after 8 cycles, req_rdy=0; rst clears err_timeout, credits=0, rsp_val=0.
//  6 Simultaneous accept+pop at credits=1 -> credits stays 1; throughput of 1 job/cycle sustained for 16 jobs.

Source files
------------

// File: rtl/pe_host_drv.sv
// Host driver for a 2x2 PE array: jobs pushed 1 cycle after accept, results returned 1 cycle after pop with their tag.
// Outstanding-job credits gate req_rdy (the PE side cannot stall us); rsp_rdy back-pressure gates pe_pop.

module fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] pop_dat
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Occupancy is tracked by the caller; it never pushes when full or pops when empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
    end
  end

  assign pop_dat = mem[rd_ptr];
endmodule

module pe_host_drv #(
  parameter int WIDTH   = 4,
  parameter int TAG_W   = 4,
  parameter int MAX_OUT = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_val,
  output logic                    req_rdy,
  input  logic [3:0][WIDTH-1:0]   req_a,
  input  logic [3:0][WIDTH-1:0]   req_b,
  input  logic [TAG_W-1:0]        req_tag,
  output logic [3:0][WIDTH-1:0]   pe_ain,
  output logic [3:0][WIDTH-1:0]   pe_bin,
  output logic                    pe_psh,
  input  logic [3:0][2*WIDTH:0]   pe_cout,
  input  logic                    pe_cout_val,
  output logic                    pe_pop,
  output logic                    rsp_val,
  input  logic                    rsp_rdy,
  output logic [3:0][2*WIDTH:0]   rsp_c,
  output logic [TAG_W-1:0]        rsp_tag,
  input  logic                    flush,
  output logic                    busy,
  output logic                    err_timeout
);
  localparam int CW = $clog2(MAX_OUT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {RUN, FLUSH, ERR} state_t;

  state_t           state;
  logic [CW-1:0]    credits;
  logic [TW-1:0]    timer;
  logic             accept;
  logic [TAG_W-1:0] tag_head;

  assign req_rdy = (state == RUN) && (credits < CW'(MAX_OUT));
  assign accept  = req_val && req_rdy;
  assign pe_pop  = pe_cout_val && (!rsp_val || rsp_rdy) && (credits != '0);
  assign busy    = (credits != '0) || rsp_val || (state != RUN);

  // Tag FIFO occupancy equals credits, so credits guard both ends.
  fifo #(.W(TAG_W), .DEPTH(MAX_OUT)) u_tag_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (accept),
    .push_dat (req_tag),
    .pop      (pe_pop),
    .pop_dat  (tag_head)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pe_psh <= 1'b0;
      pe_ain <= '0;
      pe_bin <= '0;
    end else begin
      pe_psh <= accept;
      if (accept) begin
        pe_ain <= req_a;
        pe_bin <= req_b;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      credits <= '0;
    end else begin
      case ({accept, pe_pop})
        2'b10:   credits <= credits + 1'b1;
        2'b01:   credits <= credits - 1'b1;
        default: credits <= credits;
      endcase
    end
  end

  // Stall timer: only runs while work is outstanding and nothing comes back.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer <= '0;
    end else if ((credits == '0) || pe_pop) begin
      timer <= '0;
    end else if (timer != TW'(TIMEOUT)) begin
      timer <= timer + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      err_timeout <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (timer == TW'(TIMEOUT)) begin
            state       <= ERR;
            err_timeout <= 1'b1;
          end else if (flush) begin
            state <= FLUSH;
          end
        end
        FLUSH: begin
          if (timer == TW'(TIMEOUT)) begin
            state       <= ERR;
            err_timeout <= 1'b1;
          end else if ((credits == '0) && !rsp_val) begin
            state <= RUN;
          end
        end
        default: state <= ERR;
      endcase
    end
  end

  // A pop in the same cycle as a handshake reloads, sustaining one result per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_val <= 1'b0;
      rsp_c   <= '0;
      rsp_tag <= '0;
    end else if (pe_pop) begin
      rsp_val <= 1'b1;
      rsp_c   <= pe_cout;
      rsp_tag <= tag_head;
    end else if (rsp_rdy) begin
      rsp_val <= 1'b0;
    end
  end
endmodule

// File: tb/tb_pe_host_drv.sv
// Directed + random bench for pe_host_drv with a bypassing PE-array model and a job-level reference model.
module tb_pe_host_drv;
  localparam int W  = 4;
  localparam int TG = 4;
  localparam int MO = 2;
  localparam int TO = 8;
  localparam int RW = 2 * W + 1;
  localparam int M_RUN = 0, M_FLUSH = 1, M_ERR = 2;

  typedef logic [3:0][W-1:0]  ops_t;
  typedef logic [3:0][RW-1:0] res_t;
  typedef struct packed { logic [TG-1:0] tag; res_t c; } job_t;

  logic    clk = 1'b0;
  logic    rst;
  logic    req_val, req_rdy;
  ops_t    req_a, req_b, pe_ain, pe_bin;
  logic [TG-1:0] req_tag, rsp_tag;
  logic    pe_psh, pe_cout_val, pe_pop;
  res_t    pe_cout, rsp_c;
  logic    rsp_val, rsp_rdy, flush, busy, err_timeout;

  pe_host_drv #(.WIDTH(W), .TAG_W(TG), .MAX_OUT(MO), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_val(req_val), .req_rdy(req_rdy), .req_a(req_a), .req_b(req_b),
    .req_tag(req_tag), .pe_ain(pe_ain), .pe_bin(pe_bin), .pe_psh(pe_psh), .pe_cout(pe_cout),
    .pe_cout_val(pe_cout_val), .pe_pop(pe_pop), .rsp_val(rsp_val), .rsp_rdy(rsp_rdy),
    .rsp_c(rsp_c), .rsp_tag(rsp_tag), .flush(flush), .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  job_t exp_q[$];
  res_t pe_q[$];
  logic [TG-1:0] del_q[$];
  job_t rsp_m;
  bit   rsp_val_m, psh_m, pe_en, last_acc;
  ops_t ain_m, bin_m;
  int   mode, stall, n_acc, n_pop, tg;
  res_t last_c, e1;
  logic [TG-1:0] last_tag;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic res_t matmul(input ops_t a, input ops_t b);
    res_t c;
    c[0] = RW'(int'(a[0]) * int'(b[0]) + int'(a[1]) * int'(b[2]));
    c[1] = RW'(int'(a[0]) * int'(b[1]) + int'(a[1]) * int'(b[3]));
    c[2] = RW'(int'(a[2]) * int'(b[0]) + int'(a[3]) * int'(b[2]));
    c[3] = RW'(int'(a[2]) * int'(b[1]) + int'(a[3]) * int'(b[3]));
    return c;
  endfunction

  task automatic new_req(input logic [TG-1:0] t);
    for (int i = 0; i < 4; i++) begin
      req_a[i] = W'($urandom);
      req_b[i] = W'($urandom);
    end
    req_tag = t;
  endtask

  // One clock: drive PE side, check combinational outputs, advance models, check registered outputs.
  task automatic cycle();
    bit exp_rdy, exp_pop, acc, psh_s, pop_s;
    ops_t ain_s, bin_s;
    int infl;
    if (pe_q.size() > 0) begin
      pe_cout_val = pe_en; pe_cout = pe_q[0];
    end else if (pe_psh) begin
      pe_cout_val = pe_en; pe_cout = matmul(pe_ain, pe_bin);
    end else begin
      pe_cout_val = 1'b0; pe_cout = '0;
    end
    #1;
    infl    = exp_q.size();
    exp_rdy = (mode == M_RUN) && (infl < MO);
    exp_pop = pe_cout_val && (!rsp_val_m || rsp_rdy) && (infl > 0);
    acc     = req_val && exp_rdy;
    chk("req_rdy", 64'(req_rdy), 64'(exp_rdy));
    chk("pe_pop", 64'(pe_pop), 64'(exp_pop));
    psh_s = pe_psh; ain_s = pe_ain; bin_s = pe_bin; pop_s = pe_pop;
    if (rsp_val && rsp_rdy) del_q.push_back(rsp_tag);
    @(posedge clk);
    if (psh_s) pe_q.push_back(matmul(ain_s, bin_s));
    if (pop_s && pe_q.size() > 0) void'(pe_q.pop_front());
    if (mode != M_ERR && stall == TO) mode = M_ERR;
    else if (mode == M_RUN && flush) mode = M_FLUSH;
    else if (mode == M_FLUSH && infl == 0 && !rsp_val_m) mode = M_RUN;
    if (infl == 0 || exp_pop) stall = 0;
    else if (stall < TO) stall++;
    if (exp_pop) begin
      rsp_m = exp_q.pop_front(); rsp_val_m = 1'b1; n_pop++;
    end else if (rsp_rdy) begin
      rsp_val_m = 1'b0;
    end
    psh_m = acc;
    if (acc) begin
      ain_m = req_a; bin_m = req_b;
      exp_q.push_back({req_tag, matmul(req_a, req_b)});
      n_acc++;
    end
    last_acc = acc;
    @(negedge clk);
    chk("pe_psh", 64'(pe_psh), 64'(psh_m));
    chk("pe_ain", 64'(pe_ain), 64'(ain_m));
    chk("pe_bin", 64'(pe_bin), 64'(bin_m));
    chk("rsp_val", 64'(rsp_val), 64'(rsp_val_m));
    chk("rsp_c", 64'(rsp_c), 64'(rsp_m.c));
    chk("rsp_tag", 64'(rsp_tag), 64'(rsp_m.tag));
    chk("busy", 64'(busy), 64'(exp_q.size() != 0 || rsp_val_m || mode != M_RUN));
    chk("err_timeout", 64'(err_timeout), 64'(mode == M_ERR));
    if (rsp_val) begin
      last_c = rsp_c; last_tag = rsp_tag;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; req_val = 1'b0; flush = 1'b0; pe_en = 1'b0;
    pe_cout_val = 1'b0; pe_cout = '0; rsp_rdy = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    exp_q.delete(); pe_q.delete(); rsp_m = '0; rsp_val_m = 1'b0; psh_m = 1'b0;
    ain_m = '0; bin_m = '0; mode = M_RUN; stall = 0; last_acc = 1'b0;
    chk("rst_psh", 64'(pe_psh), 64'(0));
    chk("rst_ain", 64'(pe_ain), 64'(0));
    chk("rst_bin", 64'(pe_bin), 64'(0));
    chk("rst_rsp_val", 64'(rsp_val), 64'(0));
    chk("rst_rsp_c", 64'(rsp_c), 64'(0));
    chk("rst_rsp_tag", 64'(rsp_tag), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_err", 64'(err_timeout), 64'(0));
    chk("rst_req_rdy", 64'(req_rdy), 64'(1));
    chk("rst_pe_pop", 64'(pe_pop), 64'(0));
    rst = 1'b0;
  endtask

  task automatic drain();
    req_val = 1'b0; flush = 1'b0; pe_en = 1'b1; rsp_rdy = 1'b1;
    for (int i = 0; i < 40 && (exp_q.size() > 0 || rsp_val_m || mode == M_FLUSH); i++) cycle();
  endtask

  initial begin
    req_a = '0; req_b = '0; req_tag = '0;
    do_reset();

    // Single job with known operands.
    pe_en = 1'b1; rsp_rdy = 1'b1; req_val = 1'b1; req_tag = 4'd3;
    for (int i = 0; i < 4; i++) begin
      req_a[i] = W'(i + 1); req_b[i] = W'(i + 5);
    end
    e1[0] = 9'd19; e1[1] = 9'd22; e1[2] = 9'd43; e1[3] = 9'd50;
    cycle();
    chk("t1_psh", 64'(pe_psh), 64'(1));
    req_val = 1'b0;
    drain();
    chk("t1_c", 64'(last_c), 64'(e1));
    chk("t1_tag", 64'(last_tag), 64'(3));
    chk("t1_idle", 64'(busy), 64'(0));

    // Credit limit with no results coming back.
    pe_en = 1'b0; n_acc = 0; tg = 0; new_req(TG'(tg)); req_val = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      if (last_acc) begin tg++; new_req(TG'(tg)); end
    end
    chk("t2_accepts", 64'(n_acc), 64'(2));
    chk("t2_rdy_low", 64'(req_rdy), 64'(0));
    pe_en = 1'b1;
    for (int i = 0; i < 10 && n_acc < 3; i++) begin
      cycle();
      if (last_acc) begin tg++; new_req(TG'(tg)); end
    end
    chk("t2_third", 64'(n_acc), 64'(3));
    drain();
    chk("t2_idle", 64'(busy), 64'(0));

    // Response back-pressure with two results pending.
    pe_en = 1'b0; rsp_rdy = 1'b0; del_q.delete();
    new_req(4'd5); req_val = 1'b1; cycle();
    new_req(4'd6); cycle();
    req_val = 1'b0; pe_en = 1'b1; n_pop = 0;
    repeat (6) cycle();
    chk("t3_pops", 64'(n_pop), 64'(1));
    chk("t3_hold_tag", 64'(rsp_tag), 64'(5));
    chk("t3_pop_low", 64'(pe_pop), 64'(0));
    drain();
    chk("t3_count", 64'(del_q.size()), 64'(2));
    chk("t3_first", 64'(del_q[0]), 64'(5));
    chk("t3_second", 64'(del_q[1]), 64'(6));

    // Flush together with an accept, then requests held off until drained.
    pe_en = 1'b0; rsp_rdy = 1'b1; new_req(4'd1); req_val = 1'b1; cycle();
    new_req(4'd2); flush = 1'b1; cycle(); flush = 1'b0;
    n_acc = 0; new_req(4'd9);
    repeat (4) cycle();
    chk("t4_no_acc", 64'(n_acc), 64'(0));
    chk("t4_busy", 64'(busy), 64'(1));
    pe_en = 1'b1; del_q.delete();
    for (int i = 0; i < 20 && n_acc == 0; i++) cycle();
    chk("t4_reaccept", 64'(n_acc), 64'(1));
    chk("t4_drained", 64'(del_q.size()), 64'(2));
    drain();
    chk("t4_idle", 64'(busy), 64'(0));

    // Streaming: accept and pop together every cycle.
    pe_en = 1'b1; rsp_rdy = 1'b1; n_acc = 0; del_q.delete(); req_val = 1'b1; new_req(4'd0);
    for (int i = 0; i < 16; i++) begin
      cycle();
      if (last_acc) new_req(TG'(i + 1));
    end
    chk("t6_thru", 64'(n_acc), 64'(16));
    drain();
    chk("t6_rsps", 64'(del_q.size()), 64'(16));
    chk("t6_idle", 64'(busy), 64'(0));

    // Random traffic.
    new_req(TG'($urandom));
    for (int i = 0; i < 400; i++) begin
      req_val = 1'($urandom_range(0, 1));
      rsp_rdy = ($urandom_range(0, 4) != 0);
      pe_en   = ($urandom_range(0, 4) != 0);
      flush   = ($urandom_range(0, 49) == 0);
      if (last_acc) new_req(TG'($urandom));
      cycle();
    end
    drain();
    chk("rnd_drained", 64'(rsp_val), 64'(0));

    // Timeout, late result in ERR, then reset recovery.
    do_reset();
    pe_en = 1'b0; rsp_rdy = 1'b0; new_req(4'd7); req_val = 1'b1; cycle(); req_val = 1'b0;
    repeat (TO - 1) cycle();
    chk("t5_err_early", 64'(err_timeout), 64'(0));
    repeat (2) cycle();
    chk("t5_err", 64'(err_timeout), 64'(1));
    chk("t5_rdy", 64'(req_rdy), 64'(0));
    pe_en = 1'b1; cycle();
    chk("t5_late_rsp", 64'(rsp_val), 64'(1));
    chk("t5_late_tag", 64'(rsp_tag), 64'(7));
    do_reset();
    n_acc = 0; new_req(4'd2); req_val = 1'b1;
    repeat (3) begin
      cycle();
      if (last_acc) new_req(4'd3);
    end
    chk("t5_credits", 64'(n_acc), 64'(2));
    drain();
    chk("t5_idle", 64'(busy), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
